// File: rtl/xbar_out_stage_if.sv
// rtl/xbar_out_stage_if.sv - allocator-to-crossbar bundle: ranked flits and grants in, link data and stats out
interface xbar_out_stage_if #(
  parameter int NUM_PORT = 5,
  parameter int FLIT_W   = 64,
  parameter int CNT_W    = 16
);
  logic [NUM_PORT*FLIT_W-1:0]   flit_in;
  logic [NUM_PORT-1:0]          valid_in;
  logic [NUM_PORT*NUM_PORT-1:0] alloc_in;
  logic [NUM_PORT*NUM_PORT-1:0] prod_in;
  logic                         stat_clr;
  logic [NUM_PORT*FLIT_W-1:0]   flit_out;
  logic [NUM_PORT-1:0]          valid_out;
  logic [NUM_PORT*CNT_W-1:0]    defl_cnt;
  logic                         conflict_err;

  modport master (
    output flit_in, valid_in, alloc_in, prod_in, stat_clr,
    input  flit_out, valid_out, defl_cnt, conflict_err
  );

  modport slave (
    input  flit_in, valid_in, alloc_in, prod_in, stat_clr,
    output flit_out, valid_out, defl_cnt, conflict_err
  );
endinterface

// File: rtl/xbar_out_stage.sv
// rtl/xbar_out_stage.sv - deflection-router output crossbar with hop increment, deflection stats and sticky conflict flag
module xbar_out_stage #(
  parameter int NUM_PORT = 5,
  parameter int FLIT_W   = 64,
  parameter int HOP_LSB  = 48,
  parameter int HOP_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  xbar_out_stage_if.slave bus
);

  logic [NUM_PORT*FLIT_W-1:0] flit_q, flit_d;
  logic [NUM_PORT-1:0]        valid_q, valid_d;
  logic [NUM_PORT*CNT_W-1:0]  cnt_q, cnt_d;
  logic                       err_q, err_d;

  always_comb begin
    logic [NUM_PORT-1:0]               part;
    logic [NUM_PORT-1:0]               drop;
    logic [NUM_PORT-1:0]               grant;
    logic [NUM_PORT-1:0][NUM_PORT-1:0] route;
    logic [NUM_PORT-1:0][FLIT_W-1:0]   bumped;
    logic [HOP_W-1:0]                  hop;
    logic [CNT_W-1:0]                  cnt;
    logic                              found;
    logic                              taken;
    part    = '0;
    drop    = '0;
    grant   = '0;
    route   = '0;
    bumped  = '0;
    hop     = '0;
    cnt     = '0;
    found   = 1'b0;
    taken   = 1'b0;
    flit_d  = '0;
    valid_d = '0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // Qualify each slot, reduce its grant to the lowest set bit, and pre-compute the hop-bumped flit.
    for (int i = 0; i < NUM_PORT; i++) begin
      grant   = bus.alloc_in[i*NUM_PORT +: NUM_PORT];
      part[i] = bus.valid_in[i] && (grant != '0);
      if (bus.valid_in[i] && (grant == '0)) err_d = 1'b1;
      found = 1'b0;
      for (int b = 0; b < NUM_PORT; b++) begin
        if (grant[b]) begin
          if (found) begin
            if (bus.valid_in[i]) err_d = 1'b1;
          end else begin
            route[i][b] = 1'b1;
            found       = 1'b1;
          end
        end
      end
      bumped[i] = bus.flit_in[i*FLIT_W +: FLIT_W];
      hop       = bumped[i][HOP_LSB +: HOP_W];
      if (hop != '1) bumped[i][HOP_LSB +: HOP_W] = hop + HOP_W'(1);
    end

    // Lowest-index claimant of a port wins; later claimants are dropped.
    for (int p = 0; p < NUM_PORT; p++) begin
      taken = 1'b0;
      for (int i = 0; i < NUM_PORT; i++) begin
        if (part[i] && route[i][p]) begin
          if (taken) begin
            drop[i] = 1'b1;
            err_d   = 1'b1;
          end else begin
            taken                        = 1'b1;
            valid_d[p]                   = 1'b1;
            flit_d[p*FLIT_W +: FLIT_W]   = bumped[i];
          end
        end
      end
    end

    for (int i = 0; i < NUM_PORT; i++) begin
      cnt = cnt_q[i*CNT_W +: CNT_W];
      if (bus.stat_clr) begin
        cnt = '0;
      end else if (part[i] && !drop[i] && cnt != '1 &&
                   ((bus.alloc_in[i*NUM_PORT +: NUM_PORT] &
                     bus.prod_in[i*NUM_PORT +: NUM_PORT]) == '0)) begin
        cnt = cnt + CNT_W'(1);
      end
      cnt_d[i*CNT_W +: CNT_W] = cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flit_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flit_q  <= flit_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.flit_out     = flit_q;
  assign bus.valid_out    = valid_q;
  assign bus.defl_cnt     = cnt_q;
  assign bus.conflict_err = err_q;

endmodule

// File: tb/tb_xbar_out_stage.sv
// tb/tb_xbar_out_stage.sv - directed and random checks of xbar_out_stage against a slot-by-slot allocation model
module tb_xbar_out_stage;
  localparam int NP  = 5;
  localparam int FW  = 64;
  localparam int HL  = 48;
  localparam int HW  = 8;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  xbar_out_stage_if #(.NUM_PORT(NP), .FLIT_W(FW), .CNT_W(CW))  bus ();
  xbar_out_stage_if #(.NUM_PORT(NP), .FLIT_W(FW), .CNT_W(CW2)) bus2 ();

  assign bus2.flit_in  = bus.flit_in;
  assign bus2.valid_in = bus.valid_in;
  assign bus2.alloc_in = bus.alloc_in;
  assign bus2.prod_in  = bus.prod_in;
  assign bus2.stat_clr = bus.stat_clr;

  xbar_out_stage #(.NUM_PORT(NP), .FLIT_W(FW), .HOP_LSB(HL), .HOP_W(HW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  xbar_out_stage #(.NUM_PORT(NP), .FLIT_W(FW), .HOP_LSB(HL), .HOP_W(HW), .CNT_W(CW2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

  logic [FW-1:0] s_flit [NP];
  logic          s_vld  [NP];
  logic [NP-1:0] s_alloc[NP];
  logic [NP-1:0] s_prod [NP];
  logic          s_clr;

  logic [FW-1:0] e_flit [NP];
  logic [NP-1:0] e_valid;
  int            e_cnt  [NP];
  int            e_cnt2 [NP];
  logic          e_err;

  int n_assert;
  int n_fail;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] bump(logic [FW-1:0] f);
    int h;
    h = int'(f[HL +: HW]);
    h = (h == (1 << HW) - 1) ? h : h + 1;
    f[HL +: HW] = HW'(h);
    return f;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < NP; i++) begin
      s_flit[i]  = '0;
      s_vld[i]   = 1'b0;
      s_alloc[i] = '0;
      s_prod[i]  = '0;
    end
    s_clr = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      bus.flit_in[i*FW +: FW]  = s_flit[i];
      bus.valid_in[i]          = s_vld[i];
      bus.alloc_in[i*NP +: NP] = s_alloc[i];
      bus.prod_in[i*NP +: NP]  = s_prod[i];
    end
    bus.stat_clr = s_clr;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      e_flit[i] = '0;
      e_cnt[i]  = 0;
      e_cnt2[i] = 0;
    end
    e_valid = '0;
    e_err   = 1'b0;
  endtask

  // Slots take ports in rank order; a port already taken drops the later slot.
  task automatic model_edge();
    logic [NP-1:0] claimed;
    bit            defl[NP];
    int            p;
    claimed = '0;
    e_valid = '0;
    for (int i = 0; i < NP; i++) e_flit[i] = '0;
    for (int i = 0; i < NP; i++) begin
      defl[i] = 1'b0;
      if (!s_vld[i]) continue;
      if (s_alloc[i] == '0) begin
        e_err = 1'b1;
        continue;
      end
      if ($countones(s_alloc[i]) > 1) e_err = 1'b1;
      p = 0;
      while (!s_alloc[i][p]) p++;
      if (claimed[p]) begin
        e_err = 1'b1;
        continue;
      end
      claimed[p] = 1'b1;
      e_valid[p] = 1'b1;
      e_flit[p]  = bump(s_flit[i]);
      defl[i]    = ((s_alloc[i] & s_prod[i]) == '0);
    end
    for (int i = 0; i < NP; i++) begin
      if (s_clr) begin
        e_cnt[i]  = 0;
        e_cnt2[i] = 0;
      end else if (defl[i]) begin
        e_cnt[i]  = (e_cnt[i]  == (1 << CW)  - 1) ? e_cnt[i]  : e_cnt[i]  + 1;
        e_cnt2[i] = (e_cnt2[i] == (1 << CW2) - 1) ? e_cnt2[i] : e_cnt2[i] + 1;
      end
    end
  endtask

  task automatic check_all(string tag);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s valid_out[%0d]", tag, p), 64'(bus.valid_out[p]), 64'(e_valid[p]));
      chk($sformatf("%s flit_out[%0d]", tag, p), bus.flit_out[p*FW +: FW], e_flit[p]);
      chk($sformatf("%s defl_cnt[%0d]", tag, p), 64'(bus.defl_cnt[p*CW +: CW]), 64'(e_cnt[p]));
      chk($sformatf("%s cw2 defl_cnt[%0d]", tag, p), 64'(bus2.defl_cnt[p*CW2 +: CW2]), 64'(e_cnt2[p]));
    end
    chk($sformatf("%s cw2 valid_out", tag), 64'(bus2.valid_out), 64'(e_valid));
    chk($sformatf("%s conflict_err", tag), 64'(bus.conflict_err), 64'(e_err));
    chk($sformatf("%s cw2 conflict_err", tag), 64'(bus2.conflict_err), 64'(e_err));
  endtask

  task automatic step(string tag);
    drive();
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Called just after an edge: reset lands mid-cycle and is released before the next edge.
  task automatic pulse_reset(string tag);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all(tag);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    clear_inputs();
    drive();
    model_clear();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Full load, slot i -> port (i+2)%5, all productive.
    for (int i = 0; i < NP; i++) begin
      s_vld[i]   = 1'b1;
      s_flit[i]  = {32'hC0DE_0000 + 32'(i), 32'h1000_0000 + 32'(i * 3)};
      s_alloc[i] = NP'(1) << ((i + 2) % NP);
      s_prod[i]  = s_alloc[i];
    end
    step("full_load");
    chk("full_load valid_out vector", 64'(bus.valid_out), 64'h1F);
    chk("full_load port2 carries slot0", bus.flit_out[2*FW +: FW], bump(s_flit[0]));
    step("full_load2");
    pulse_reset("midstream_reset");
    chk("midstream_reset valid_out", 64'(bus.valid_out), 64'h0);
    step("after_reset");

    // Straight-through with hop 0x05.
    clear_inputs();
    s_vld[0]   = 1'b1;
    s_flit[0]  = 64'h1105_2233_4455_6677;
    s_alloc[0] = 5'b00100;
    s_prod[0]  = 5'b00100;
    step("straight");
    chk("straight hop", 64'(bus.flit_out[2*FW + HL +: HW]), 64'h06);
    chk("straight valid_out", 64'(bus.valid_out), 64'h04);

    // Deflection with hop saturation.
    clear_inputs();
    s_vld[1]   = 1'b1;
    s_flit[1]  = 64'hABFF_0102_0304_0506;
    s_alloc[1] = 5'b00001;
    s_prod[1]  = 5'b00010;
    for (int k = 0; k < 3; k++) step("deflect");
    chk("deflect hop saturated", 64'(bus.flit_out[HL +: HW]), 64'hFF);
    chk("deflect cnt1 after 3", 64'(bus.defl_cnt[1*CW +: CW]), 64'd3);
    for (int k = 0; k < 2; k++) step("deflect_more");
    chk("cw2 cnt1 saturated", 64'(bus2.defl_cnt[1*CW2 +: CW2]), 64'd3);
    chk("cw16 cnt1 after 5", 64'(bus.defl_cnt[1*CW +: CW]), 64'd5);

    // stat_clr wins over a same-cycle deflection.
    clear_inputs();
    s_vld[4]   = 1'b1;
    s_flit[4]  = 64'h0010_0000_0000_0044;
    s_alloc[4] = 5'b00010;
    s_prod[4]  = 5'b00001;
    for (int k = 0; k < 7; k++) step("defl4");
    chk("cnt4 before clear", 64'(bus.defl_cnt[4*CW +: CW]), 64'd7);
    s_clr = 1'b1;
    step("clr_collision");
    chk("cnt4 after clear", 64'(bus.defl_cnt[4*CW +: CW]), 64'd0);
    chk("no conflict yet", 64'(bus.conflict_err), 64'd0);

    // Port conflict: slot0 wins over slot3; flag is sticky through stat_clr.
    clear_inputs();
    s_vld[0]   = 1'b1;
    s_vld[3]   = 1'b1;
    s_flit[0]  = 64'h0A01_0000_0000_00A0;
    s_flit[3]  = 64'h0B02_0000_0000_00B3;
    s_alloc[0] = 5'b01000;
    s_alloc[3] = 5'b01000;
    s_prod[0]  = 5'b01000;
    s_prod[3]  = 5'b01000;
    step("conflict");
    chk("conflict port3 = slot0", bus.flit_out[3*FW +: FW], 64'h0A02_0000_0000_00A0);
    chk("conflict flag set", 64'(bus.conflict_err), 64'd1);
    clear_inputs();
    s_clr = 1'b1;
    step("conflict_clr");
    s_clr = 1'b0;
    step("conflict_hold");
    chk("conflict sticky", 64'(bus.conflict_err), 64'd1);
    pulse_reset("conflict_reset");
    chk("conflict cleared by reset", 64'(bus.conflict_err), 64'd0);

    // Random traffic with occasional reset and stat_clr.
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 50) pulse_reset("rand_reset");
      for (int i = 0; i < NP; i++) begin
        s_vld[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8) s_alloc[i] = NP'(1) << $urandom_range(0, NP - 1);
        else                          s_alloc[i] = NP'($urandom_range(0, 31));
        s_prod[i] = NP'($urandom_range(0, 31));
        s_flit[i] = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) s_flit[i][HL +: HW] = '1;
      end
      s_clr = ($urandom_range(0, 19) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/xbar_out_stage.md
Name: xbar_out_stage

Overview:
- Stage directly downstream of the last-stage port allocator in the bufferless deflection router.
- Takes the NUM_PORT ranked flits with their final one-hot output grants and switches each flit through the crossbar.
- Increments each flit's hop-count field and registers the result onto the output links.
- Keeps per-input deflection statistics and a sticky grant-conflict error flag.

Parameters:
NUM_PORT, 5, number of router ports (N, E, S, W, local).
FLIT_W, 64, flit width in bits.
HOP_LSB, 48, LSB position of hop-count field within flit.
HOP_W, 8, hop-count field width.
CNT_W, 16, width of each deflection counter.

Ports:
clk  input  1  router clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
flit_in  input  NUM_PORT*FLIT_W  ranked flits, slot i at [i*FLIT_W +: FLIT_W].
valid_in  input  NUM_PORT  slot i holds a live flit.
alloc_in  input  NUM_PORT*NUM_PORT  one-hot grant per slot, slot i at [i*NUM_PORT +: NUM_PORT].
prod_in  input  NUM_PORT*NUM_PORT  productive-port request per slot, same packing.
stat_clr  input  1  synchronous clear of all deflection counters.
flit_out  output  NUM_PORT*FLIT_W  registered output link data, port p at [p*FLIT_W +: FLIT_W].
valid_out  output  NUM_PORT  registered output link valid.
defl_cnt  output  NUM_PORT*CNT_W  per-slot deflection counters.
conflict_err  output  1  sticky: two valid slots granted the same port.

Behaviour:
- Reset (reset_n low, async): flit_out=0, valid_out=0, defl_cnt=0, conflict_err=0. Reset asserted mid-stream discards in-flight flits. There is no recovery handshake: the first edge after release samples inputs normally.
- Latency: exactly 1 cycle from inputs to flit_out/valid_out. There is no backpressure, because the router is bufferless.
- Grant qualification:
  - A slot participates only if valid_in[i]=1 and alloc_in slot i is nonzero.
  - A valid slot with an all-zero grant is dropped and sets conflict_err.
  - Grants of invalid slots are ignored.
- Crossbar: port p takes the flit of the lowest-index participating slot whose grant bit p=1; lowest index is highest rank. valid_out[p]=1 iff such a slot exists, otherwise flit_out[p]=0.
- Conflict:
  - If two or more participating slots target the same port, the lowest index wins and the others are dropped.
  - conflict_err is set and stays at 1 until reset; stat_clr does not clear it.
  - A grant with more than one bit set (not one-hot) also sets conflict_err; that flit is routed to its lowest set bit.
- Hop count:
  - The output flit equals the input flit, except bits [HOP_LSB +: HOP_W] are incremented by 1.
  - Saturates at all-ones, with no wrap.
- Deflection count:
  - A slot is deflected when it participates and (alloc & prod)==0 for that slot.
  - The slot's counter increments by 1 and saturates at 2^CNT_W-1.
  - stat_clr has priority over a simultaneous increment: the counter becomes 0 that cycle.
  - Dropped (conflicting) slots are not counted as deflected.
- Counters and conflict_err are registered and update on the same edge as the outputs.

Test Plan:
- Reset: drive valid_in=5'b11111 with legal grants, assert reset_n=0 between edges → all outputs 0 immediately; first edge after release → outputs follow inputs.
- Straight-through:
  - Stimulus: slot0 flit 0x..00_05_..., grant 00100, prod 00100, other slots invalid.
  - Response: next cycle valid_out=00100, flit_out[2] hop field=0x06, defl_cnt[0] unchanged, conflict_err=0.
- Deflection with saturation:
  - Stimulus: slot1 hop=0xFF, grant 00001, prod 00010, for 3 cycles.
  - Response: hop stays 0xFF; defl_cnt[1]=3. With CNT_W=2 and 5 cycles, defl_cnt[1] holds at 3.
- Conflict:
  - Stimulus: slots 0 and 3 both valid with grant 01000.
  - Response: flit_out[3]=slot0 flit, slot3 dropped, conflict_err=1. It stays 1 after stat_clr pulses and clears only on reset_n=0.
- Full load: all 5 slots valid with a permutation grant (e.g. slot i→port (i+2)%5) → valid_out=11111, each port carries the correct flit with hop+1.
- stat_clr collision: stat_clr=1 in the same cycle slot4 is deflected with defl_cnt[4]=7 → defl_cnt[4]=0 next cycle (not 1).
